alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Control stage wrapped around the team's combinational arithmetic units: the 4-bit ripple-carry adder and the n×m array multiplier.
- Accepts one operation at a time over a valid/ready handshake and registers the operands.
- Drives the adder and multiplier inputs, waiting a fixed number of cycles on the slow multiplier path.
- Captures the unit outputs and presents a registered result downstream with valid/ready backpressure. SUB is built from two sequenced adder passes because the adder has no carry-in.

Parameters:
- WIDTH, 4: operand width; matches adder width and multiplier n = m = WIDTH.
- MUL_WAIT, 2: cycles operands are held on the multiplier before the product is captured; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer can accept a request.
- in_op  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 XOR.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- add_x  out  WIDTH  adder x input.
- add_y  out  WIDTH  adder y input.
- add_sum  in  WIDTH  adder result.
- add_carry  in  1  adder carry out.
- mul_a  out  WIDTH  multiplier a input.
- mul_b  out  WIDTH  multiplier b input.
- mul_prod  in  2*WIDTH  multiplier product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  2*WIDTH  result; ADD/SUB/XOR results are zero-extended.
- out_carry  out  1  ADD: carry out. SUB: 1 = no borrow. MUL/XOR: 0.
- out_op  out  2  opcode of the presented result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State is IDLE; op_r, a_r, b_r, tmp_r and the wait counter are 0.
  - in_ready=1 as soon as reset releases.
  - out_valid=0, out_result=0, out_carry=0, out_op=0.
  - add_x, add_y, mul_a, mul_b are all 0.
- States: IDLE, EXEC1, EXEC2, MULW, DONE.
- in_ready = (state==IDLE). There is no overlap; a new request is accepted only in IDLE.
- IDLE:
  - Accept on in_valid & in_ready; latch op/a/b.
  - Next state: MUL goes to MULW with counter = MUL_WAIT-1. All other ops go to EXEC1.
- EXEC1:
  - ADD: add_x=a_r, add_y=b_r; capture add_sum and add_carry at the edge; go to DONE.
  - SUB: add_x=a_r, add_y=~b_r; store add_sum in tmp_r and add_carry in c1_r; go to EXEC2.
  - XOR: out_result = a_r ^ b_r, computed internally with the adder unused; go to DONE.
- EXEC2 (SUB only):
  - add_x=tmp_r, add_y=1.
  - Capture result = add_sum and out_carry = c1_r | add_carry; go to DONE.
- MULW:
  - mul_a=a_r, mul_b=b_r, held stable for the whole state.
  - Decrement the counter; when it is 0, capture mul_prod and go to DONE.
- Unit input driving: adder inputs are 0 outside EXEC1/EXEC2; multiplier inputs are 0 outside MULW.
- DONE:
  - out_valid=1, with out_result, out_carry and out_op stable.
  - On out_ready, go to IDLE, drop out_valid and clear the outputs to 0.
  - out_ready while out_valid=0 has no effect.
- Latency, counted in edges from the accept edge until out_valid is high:
  - ADD and XOR: 2.
  - SUB: 3.
  - MUL: 1+MUL_WAIT.
- The earliest next accept is the cycle after the out_valid & out_ready handshake.
- Boundaries:
  - in_valid in any non-IDLE state is ignored; no request is lost because in_ready is 0.
  - Held backpressure (out_ready=0) keeps DONE and the outputs unchanged indefinitely.
  - rst_n asserted mid-operation aborts the operation immediately (asynchronous); all registers return to reset values and the result is discarded.
  - SUB wrap: the result is modulo 2^WIDTH. Carry is derived only from c1 | c2, never from the sign.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_XOR;
  - state encoding localparams;
  - the ALU_OPW=2 constant.
- Single module; the counter and FSM are inline.
- The adder and multiplier stay external; the bench instantiates ripple_carry_adder and multiply_m (n=m=WIDTH) on the unit ports.

Test Plan (WIDTH=4, MUL_WAIT=2, real units attached):
- ADD a=9, b=8 -> out_result=0x01, out_carry=1, out_op=00; out_valid exactly 2 edges after accept.
- SUB a=5, b=3 -> 0x02, carry 1. SUB a=3, b=5 -> 0x0E, carry 0. SUB a=0, b=0 -> 0x00, carry 1 (c2 path). Each has out_valid 3 edges after accept.
- MUL a=15, b=15 -> 0xE1, carry 0; mul_a/mul_b stable at 15 for 2 cycles; out_valid 3 edges after accept. XOR a=0xA, b=0x6 -> 0x0C.
- Backpressure: ADD 1+1 with out_ready=0 for 5 cycles -> 0x02 held, in_ready=0; a MUL pulsed meanwhile is not accepted. After the out_ready handshake, in_ready=1 on the next cycle.
- Reset: rst_n low for 1 cycle mid-MULW -> out_valid=0, in_ready=1 after release; the next ADD 2+3 returns 0x05 with no stale product.
- Back-to-back: in_valid held high with 4 queued ops and out_ready=1 -> all 4 results in order, each accepted only in IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes and FSM state encoding.
package alu_pkg;

    localparam int ALU_OPW = 2;

    localparam logic [ALU_OPW-1:0] OP_ADD = 2'b00;
    localparam logic [ALU_OPW-1:0] OP_SUB = 2'b01;
    localparam logic [ALU_OPW-1:0] OP_MUL = 2'b10;
    localparam logic [ALU_OPW-1:0] OP_XOR = 2'b11;

    localparam int STW = 3;
    localparam logic [STW-1:0] ST_IDLE  = 3'd0;
    localparam logic [STW-1:0] ST_EXEC1 = 3'd1;
    localparam logic [STW-1:0] ST_EXEC2 = 3'd2;
    localparam logic [STW-1:0] ST_MULW  = 3'd3;
    localparam logic [STW-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one ADD/SUB/MUL/XOR at a time through external adder and multiplier units
// and holds the registered result until downstream accepts it.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MUL_WAIT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALU_OPW-1:0]   in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     add_x,
    output logic [WIDTH-1:0]     add_y,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_carry,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_carry,
    output logic [ALU_OPW-1:0]   out_op
);

    logic [STW-1:0]     state_r;
    logic [STW-1:0]     state_s;
    logic [ALU_OPW-1:0] op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   tmp_r;
    logic               c1_r;
    logic [3:0]         cnt_r;
    logic [2*WIDTH-1:0] res_r;
    logic               carry_r;
    logic               valid_r;
    logic [ALU_OPW-1:0] out_op_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (in_valid) state_s = (in_op == OP_MUL) ? ST_MULW : ST_EXEC1;
                      else          state_s = ST_IDLE;
            ST_EXEC1: state_s = (op_r == OP_SUB) ? ST_EXEC2 : ST_DONE;
            ST_EXEC2: state_s = ST_DONE;
            ST_MULW:  state_s = (cnt_r == 4'd0) ? ST_DONE : ST_MULW;
            ST_DONE:  state_s = out_ready ? ST_IDLE : ST_DONE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Unit input drive: operands reach a unit only while that unit is in use
    always_comb begin
        add_x    = {WIDTH{1'b0}};
        add_y    = {WIDTH{1'b0}};
        mul_a    = {WIDTH{1'b0}};
        mul_b    = {WIDTH{1'b0}};
        in_ready = (state_r == ST_IDLE);
        case (state_r)
            ST_EXEC1: begin
                add_x = a_r;
                add_y = (op_r == OP_SUB) ? ~b_r : b_r;
            end
            ST_EXEC2: begin
                add_x = tmp_r;
                add_y = {{(WIDTH-1){1'b0}}, 1'b1};
            end
            ST_MULW: begin
                mul_a = a_r;
                mul_b = b_r;
            end
            default: begin
                add_x = {WIDTH{1'b0}};
                mul_a = {WIDTH{1'b0}};
            end
        endcase
    end

    // Operand latch, wait counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= OP_ADD;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            tmp_r    <= {WIDTH{1'b0}};
            c1_r     <= 1'b0;
            cnt_r    <= 4'd0;
            res_r    <= {(2*WIDTH){1'b0}};
            carry_r  <= 1'b0;
            valid_r  <= 1'b0;
            out_op_r <= OP_ADD;
        end else begin
            valid_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r  <= in_op;
                        a_r   <= in_a;
                        b_r   <= in_b;
                        cnt_r <= 4'(MUL_WAIT - 1);
                    end
                end
                ST_EXEC1: begin
                    out_op_r <= op_r;
                    case (op_r)
                        OP_ADD: begin
                            res_r   <= {{WIDTH{1'b0}}, add_sum};
                            carry_r <= add_carry;
                        end
                        OP_SUB: begin
                            tmp_r <= add_sum;
                            c1_r  <= add_carry;
                        end
                        OP_XOR: begin
                            res_r   <= {{WIDTH{1'b0}}, a_r ^ b_r};
                            carry_r <= 1'b0;
                        end
                        default: begin
                            res_r   <= {(2*WIDTH){1'b0}};
                            carry_r <= 1'b0;
                        end
                    endcase
                end
                // Second SUB pass adds the +1 of two's complement; either pass may carry
                ST_EXEC2: begin
                    res_r   <= {{WIDTH{1'b0}}, add_sum};
                    carry_r <= c1_r | add_carry;
                end
                ST_MULW: begin
                    if (cnt_r == 4'd0) begin
                        res_r    <= mul_prod;
                        carry_r  <= 1'b0;
                        out_op_r <= op_r;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        res_r    <= {(2*WIDTH){1'b0}};
                        carry_r  <= 1'b0;
                        out_op_r <= OP_ADD;
                    end
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign out_valid  = valid_r;
    assign out_result = res_r;
    assign out_carry  = carry_r;
    assign out_op     = out_op_r;

endmodule
